// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and limits for the firebird7_in gate1 guarded IJTAG data mux.
// Optional parity output: FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN.
package firebird7_in_gate1_tessent_data_mux_pkg;

  typedef enum logic [1:0] {
    FUNC  = 2'd0,
    G2IJ  = 2'd1,
    IJTAG = 2'd2,
    G2FN  = 2'd3
  } ch_state_e;

  localparam int CNT_W     = 4;
  localparam int GUARD_MAX = 15;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_ch.sv
// One channel: select FSM with guard counter and registered data word.
// Optional parity bit: FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN.
import firebird7_in_gate1_tessent_data_mux_pkg::*;

module firebird7_in_gate1_tessent_data_mux_ch #(
  parameter int WIDTH        = 3,
  parameter int GUARD_CYCLES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             sel,
  input  logic [WIDTH-1:0] func_data,
  input  logic [WIDTH-1:0] ijtag_data,
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
  output logic             data_parity,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             ijtag_active,
  output logic             switching
);

  localparam bit HAS_GUARD = GUARD_CYCLES > 0;
  localparam logic [CNT_W-1:0] GUARD_LD =
    CNT_W'(HAS_GUARD ? GUARD_CYCLES - 1 : 0);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] data_nxt;

  // Decision uses the current state, so the first edge
  // seeing a new select still loads the old source.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    unique case (state)
      FUNC: begin
        data_nxt = func_data;
        if (sel) begin
          if (HAS_GUARD) begin
            state_nxt = G2IJ;
            cnt_nxt   = GUARD_LD;
          end else begin
            state_nxt = IJTAG;
          end
        end
      end
      G2IJ: begin
        if (!sel)
          state_nxt = FUNC;
        else if (cnt == '0)
          state_nxt = IJTAG;
        else
          cnt_nxt = cnt - CNT_W'(1);
      end
      IJTAG: begin
        data_nxt = ijtag_data;
        if (!sel) begin
          if (HAS_GUARD) begin
            state_nxt = G2FN;
            cnt_nxt   = GUARD_LD;
          end else begin
            state_nxt = FUNC;
          end
        end
      end
      G2FN: begin
        if (sel)
          state_nxt = IJTAG;
        else if (cnt == '0)
          state_nxt = FUNC;
        else
          cnt_nxt = cnt - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state        <= FUNC;
      cnt          <= '0;
      data_out     <= '0;
      ijtag_active <= 1'b0;
      switching    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      data_out     <= data_nxt;
      ijtag_active <= state_nxt == IJTAG;
      switching    <= (state_nxt == G2IJ) || (state_nxt == G2FN);
    end
  end

`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset)
      data_parity <= 1'b0;
    else
      data_parity <= ^data_nxt;
  end
`endif

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
// Multi-channel registered IJTAG/functional data mux with guarded switchover.
// Optional per-channel parity: FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN.
import firebird7_in_gate1_tessent_data_mux_pkg::*;

module firebird7_in_gate1_tessent_data_mux_seq #(
  parameter int WIDTH        = 3,
  parameter int NUM_CH       = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic [NUM_CH-1:0]       ijtag_select,
  input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
  input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
  output logic [NUM_CH-1:0]       data_parity,
`endif
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       ijtag_active,
  output logic [NUM_CH-1:0]       switching
);

  if (GUARD_CYCLES < 0 || GUARD_CYCLES > GUARD_MAX) begin : g_bad_guard
    $error("GUARD_CYCLES out of range 0..15");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    firebird7_in_gate1_tessent_data_mux_ch #(
      .WIDTH        (WIDTH),
      .GUARD_CYCLES (GUARD_CYCLES)
    ) u_ch (
      .ijtag_tck    (ijtag_tck),
      .ijtag_reset  (ijtag_reset),
      .sel          (ijtag_select[c]),
      .func_data    (functional_data_in[c*WIDTH +: WIDTH]),
      .ijtag_data   (ijtag_data_in[c*WIDTH +: WIDTH]),
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
      .data_parity  (data_parity[c]),
`endif
      .data_out     (data_out[c*WIDTH +: WIDTH]),
      .ijtag_active (ijtag_active[c]),
      .switching    (switching[c])
    );
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_seq.sv
// Bench for the guarded IJTAG data mux: scoreboard on a GUARD_CYCLES=2
// instance plus direct checks on a GUARD_CYCLES=0 instance.
module tb_firebird7_in_gate1_tessent_data_mux_seq;

  logic       tck = 1'b0;
  logic       rst;
  logic [1:0] sel, sel_z;
  logic [5:0] f, j;
  logic [5:0] d0, d1;
  logic [1:0] a0, s0, a1, s1;
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
  logic [1:0] p0, p1;
`endif

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_mux_seq #(
    .WIDTH(3), .NUM_CH(2), .GUARD_CYCLES(2)
  ) u_dut (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst),
    .ijtag_select       (sel),
    .functional_data_in (f),
    .ijtag_data_in      (j),
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
    .data_parity        (p0),
`endif
    .data_out           (d0),
    .ijtag_active       (a0),
    .switching          (s0)
  );

  firebird7_in_gate1_tessent_data_mux_seq #(
    .WIDTH(3), .NUM_CH(2), .GUARD_CYCLES(0)
  ) u_dut_g0 (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst),
    .ijtag_select       (sel_z),
    .functional_data_in (f),
    .ijtag_data_in      (j),
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
    .data_parity        (p1),
`endif
    .data_out           (d1),
    .ijtag_active       (a1),
    .switching          (s1)
  );

  typedef struct packed {
    logic [5:0] d;
    logic [1:0] a;
    logic [1:0] s;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, then pop and compare after it.
  task automatic step(string tag, logic [5:0] d, logic [1:0] a,
                      logic [1:0] s);
    exp_t e;
    e.d = d;
    e.a = a;
    e.s = s;
    sb.push_back(e);
    @(posedge tck);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".data"}, 32'(d0), 32'(e.d));
      check({tag, ".act"},  32'(a0), 32'(e.a));
      check({tag, ".sw"},   32'(s0), 32'(e.s));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    sel   = 2'b00;
    sel_z = 2'b00;
    f     = {3'b011, 3'b101};
    j     = {3'b110, 3'b010};
    #2;
    check("rst0.data", 32'(d0), 32'd0);
    check("rst0.act",  32'(a0), 32'd0);
    check("rst0.sw",   32'(s0), 32'd0);
    #5;
    rst = 1'b0;

    step("func",  6'b011_101, 2'b00, 2'b00);

    sel = 2'b01;
    step("gsw.k",   6'b011_101, 2'b00, 2'b01);
    step("gsw.k1",  6'b011_101, 2'b00, 2'b01);
    step("gsw.k2",  6'b011_101, 2'b01, 2'b00);
    step("gsw.k3",  6'b011_010, 2'b01, 2'b00);

    sel = 2'b11;
    step("ch1up.1", 6'b011_010, 2'b01, 2'b10);
    step("ch1up.2", 6'b011_010, 2'b01, 2'b10);
    step("ch1up.3", 6'b011_010, 2'b11, 2'b00);
    step("ch1up.4", 6'b110_010, 2'b11, 2'b00);

    sel = 2'b10;
    step("ch0dn.1", 6'b110_010, 2'b10, 2'b01);
    step("ch0dn.2", 6'b110_010, 2'b10, 2'b01);
    step("ch0dn.3", 6'b110_010, 2'b10, 2'b00);
    step("ch0dn.4", 6'b110_101, 2'b10, 2'b00);

    sel = 2'b01;
    f   = {3'b001, 3'b111};
    j   = {3'b100, 3'b011};
    step("indep.1", 6'b100_111, 2'b00, 2'b11);
    step("indep.2", 6'b100_111, 2'b00, 2'b11);
    step("indep.3", 6'b100_111, 2'b01, 2'b00);
    step("indep.4", 6'b001_011, 2'b01, 2'b00);

    sel = 2'b11;
    step("abort.1", 6'b001_011, 2'b01, 2'b10);
    sel = 2'b01;
    f   = {3'b110, 3'b111};
    step("abort.2", 6'b001_011, 2'b01, 2'b00);
    step("abort.3", 6'b110_011, 2'b01, 2'b00);

    sel = 2'b00;
    step("midg.1",  6'b110_011, 2'b00, 2'b01);
    #3;
    sel = 2'b11;
    rst = 1'b1;
    #1;
    check("rstm.data", 32'(d0), 32'd0);
    check("rstm.act",  32'(a0), 32'd0);
    check("rstm.sw",   32'(s0), 32'd0);
    @(posedge tck);
    #1;
    check("rsth.data", 32'(d0), 32'd0);
    check("rsth.sw",   32'(s0), 32'd0);
    #2;
    rst = 1'b0;
    step("post.1",  6'b110_111, 2'b00, 2'b11);

    sel = 2'b00;
    f   = {3'b001, 3'b101};
    j   = {3'b100, 3'b010};
    @(posedge tck);
    #1;
    check("g0.func.data", 32'(d1[2:0]), 32'b101);
    check("g0.func.sw",   32'(s1), 32'd0);
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
    check("g0.func.par",  32'(p1[0]), 32'd0);
`endif
    sel_z = 2'b01;
    @(posedge tck);
    #1;
    check("g0.k.data", 32'(d1[2:0]), 32'b101);
    check("g0.k.act",  32'(a1), 32'b01);
    check("g0.k.sw",   32'(s1), 32'd0);
    @(posedge tck);
    #1;
    check("g0.k1.data", 32'(d1[2:0]), 32'b010);
    check("g0.k1.act",  32'(a1), 32'b01);
    check("g0.k1.sw",   32'(s1), 32'd0);
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN
    check("g0.k1.par",  32'(p1[0]), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_seq.md
# firebird7_in_gate1_tessent_data_mux_seq

Registered, multi-channel successor to the gate-level IJTAG data mux. Each of NUM_CH channels independently steers a WIDTH-bit data path between functional data and IJTAG data, with a guarded switchover. During the guard window the output holds its last value, so a select change never produces a mixed or glitching word. The block sits between IJTAG SIB/TDR instruments and the functional logic they override in the firebird7_in gate1 partition.

## Interface
- WIDTH, 3: data bits per channel.
- NUM_CH, 4: number of independent channels.
- GUARD_CYCLES, 2: hold cycles on each select transition; legal range 0..15.
- ijtag_tck  in  1: sole clock, rising edge.
- ijtag_reset  in  1: reset, asynchronous, active-high.
- ijtag_select  in  NUM_CH: per-channel request; 1 selects IJTAG data, 0 selects functional data.
- functional_data_in  in  NUM_CH*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
- ijtag_data_in  in  NUM_CH*WIDTH: same packing as functional_data_in.
- data_out  out  NUM_CH*WIDTH: registered muxed data, same packing.
- ijtag_active  out  NUM_CH: channel is in state IJTAG.
- switching  out  NUM_CH: channel is in a guard state.

## Operation
- Each channel runs an independent 4-state FSM: FUNC, G2IJ (guard to IJTAG), IJTAG, G2FN (guard to functional).
- FUNC:
  - ijtag_select=1 and GUARD_CYCLES>0 -> G2IJ, with guard counter loaded to GUARD_CYCLES-1.
  - ijtag_select=1 and GUARD_CYCLES=0 -> IJTAG directly.
  - Otherwise stay in FUNC.
- G2IJ:
  - ijtag_select=0 -> abort to FUNC.
  - Counter=0 -> IJTAG.
  - Otherwise decrement the counter.
- IJTAG: mirrors FUNC with the select polarity reversed, going to G2FN (or to FUNC when GUARD_CYCLES=0).
- G2FN:
  - ijtag_select=1 -> abort to IJTAG.
  - Counter=0 -> FUNC.
  - Otherwise decrement the counter.
- data_out register, per channel, on each edge:
  - FUNC: loads functional_data_in.
  - IJTAG: loads ijtag_data_in.
  - G2IJ, G2FN: holds its current value.
- The select-to-transition decision uses the current state, not the next state. The first clock that sees the new select value therefore still loads the old source.
- Channels share no state. Simultaneous transitions on any subset of channels are independent.
- A select pulse shorter than the guard window aborts the switch and leaves the source unchanged.

## Timing
- Reset, asynchronous, takes effect immediately and overrides everything, including mid-guard:
  - data_out=0, ijtag_active=0, switching=0.
  - All FSMs in FUNC, all counters 0.
- Data latency: data_out follows the selected source with 1 cycle latency in steady state.
- Switch latency: a select edge sampled at edge k shows the new source on data_out after edge k+GUARD_CYCLES+1.
- With GUARD_CYCLES=0: the new source shows after edge k+1, and switching never asserts.
- ijtag_active and switching are registered. They reflect the FSM state after each edge and are one-hot-or-zero per channel.
- First edge after reset release: a sampled ijtag_select=1 starts a normal guarded switch. There is no special-case behaviour.

## Configuration
- Macro: FIREBIRD7_IN_GATE1_DATA_MUX_PARITY_EN.
- Defined:
  - Adds output port data_parity  out  NUM_CH.
  - Each bit is the registered even parity (XOR reduction) of that channel's next data_out value, updated on the same edge as data_out.
  - Parity holds during guard states; reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package firebird7_in_gate1_tessent_data_mux_pkg holds:
  - The state enum (FUNC, G2IJ, IJTAG, G2FN; 2-bit encoding).
  - The guard counter width constant (4 bits).
  - The maximum GUARD_CYCLES constant (15), used in an elaboration-time range check.
- Sub-module firebird7_in_gate1_tessent_data_mux_ch: one channel (FSM, counter, WIDTH-bit data register, optional parity bit).
- Top level is a generate loop over NUM_CH that slices the packed buses.

## Test plan
All scenarios use WIDTH=3, NUM_CH=2, GUARD_CYCLES=2 unless stated otherwise.
- Reset:
  - Stimulus: assert ijtag_reset mid-cycle with ijtag_select=2'b11 and inputs non-zero.
  - Required response: data_out=6'b0, ijtag_active=0 and switching=0 immediately, without waiting for a clock edge.
- Steady functional:
  - Stimulus: select=0, functional ch0=3'b101, ijtag ch0=3'b010.
  - Required response: data_out ch0=3'b101 one edge later; ijtag_active=0.
- Guarded switch:
  - Stimulus: ch0 data_out=3'b101, raise ch0 select at edge k, ijtag ch0=3'b010.
  - Required response: switching=1 and data_out=3'b101 through edges k and k+1; data_out=3'b010 and ijtag_active=1 after edge k+3.
- Abort:
  - Stimulus: raise ch0 select for a single cycle.
  - Required response: switching pulses for 1 cycle; data_out never leaves functional data; ch0 returns to FUNC.
- Independence:
  - Stimulus: ch0 switches to IJTAG while ch1 switches IJTAG->FUNC on the same edge.
  - Required response: both complete after 3 edges with no interaction between channels.
- GUARD_CYCLES=0 and parity:
  - Stimulus: rerun the guarded switch scenario with GUARD_CYCLES=0 and the parity macro defined.
  - Required response: data_out=3'b010 one edge after the select edge; switching stays 0; data_parity[0]=1.
